// File: rtl/bidir_pad_sched.sv
// Half-duplex scheduler for one shared DDR bidirectional pad: round-robin arbitration
// between two requesters, 2-bit/clk serialise on write, deserialise on read, turnaround guard.
module bidir_pad_sched #(
  parameter int WORD_W   = 16,
  parameter int TURN_CYC = 2,
  parameter int IN_LAT   = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [WORD_W-1:0] req_wdata0,
  input  logic [WORD_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              pad_oe,
  output logic              pad_dout0,
  output logic              pad_dout1,
  input  logic              pad_din0,
  input  logic              pad_din1,
  output logic              pad_cken,
  output logic              pad_latch
);

  // state | meaning
  // IDLE  | waiting for a request; ready given to the granted requester only
  // TURN  | oe-low guard cycles before a direction change
  // TX    | driving one bit pair per clock, MSB first
  // RX    | pad input unlatched; first IN_LAT pairs discarded, then shifted in
  // RESP  | one-cycle read completion pulse to the owning requester

  localparam int HALF  = WORD_W / 2;
  localparam int RX_N  = HALF + IN_LAT;
  localparam int MAXC  = (RX_N > TURN_CYC) ? RX_N : TURN_CYC;
  localparam int CNT_W = $clog2(MAXC + 1);

  if (WORD_W < 2 || (WORD_W % 2) != 0) begin : g_bad_word_w
    $error("bidir_pad_sched: WORD_W must be even and >= 2");
  end
  if (TURN_CYC < 1) begin : g_bad_turn
    $error("bidir_pad_sched: TURN_CYC must be >= 1");
  end
  if (IN_LAT < 0 || IN_LAT > 3) begin : g_bad_lat
    $error("bidir_pad_sched: IN_LAT must be in 0..3");
  end

  typedef enum logic [2:0] {IDLE, TURN, TX, RX, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              last_dir;   // 1 = write, 0 = read
  logic              rr_ptr;
  logic              id_q;
  logic              dir_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] tx_sh;
  logic [WORD_W-1:0] rx_sh;

  logic              accept;
  logic              g_idx;
  logic              g_write;
  logic [WORD_W-1:0] g_data;
  logic [WORD_W-1:0] tx_src;
  logic [WORD_W-1:0] rx_next;
  logic              enter_tx;
  logic              enter_rx;

  always_comb begin
    accept    = (state == IDLE) && (|req_valid);
    g_idx     = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    g_write   = req_write[g_idx];
    g_data    = g_idx ? req_wdata1 : req_wdata0;
    req_ready = 2'b00;
    if (accept) req_ready[g_idx] = 1'b1;
    tx_src    = (state == IDLE) ? g_data : wdata_q;
    rx_next   = (rx_sh << 2) | WORD_W'({pad_din0, pad_din1});
    enter_tx  = (accept && g_write && last_dir) ||
                (state == TURN && cnt == '0 && dir_q);
    enter_rx  = (accept && !g_write && !last_dir) ||
                (state == TURN && cnt == '0 && !dir_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      last_dir   <= 1'b0;
      rr_ptr     <= 1'b0;
      id_q       <= 1'b0;
      dir_q      <= 1'b0;
      wdata_q    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      resp_valid <= 2'b00;
      resp_rdata <= '0;
      pad_oe     <= 1'b0;
      pad_dout0  <= 1'b0;
      pad_dout1  <= 1'b0;
      pad_cken   <= 1'b0;
      pad_latch  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          id_q    <= g_idx;
          dir_q   <= g_write;
          wdata_q <= g_data;
          rr_ptr  <= ~g_idx;
          if (g_write != last_dir) begin
            state    <= TURN;
            cnt      <= CNT_W'(TURN_CYC - 1);
            pad_oe   <= 1'b0;
            pad_cken <= 1'b1;
          end
        end
        TURN: begin
          if (cnt == '0) last_dir <= dir_q;
          else           cnt      <= cnt - 1'b1;
        end
        TX: begin
          if (cnt == '0) begin
            state     <= IDLE;
            pad_oe    <= 1'b0;
            pad_cken  <= 1'b0;
            pad_dout0 <= 1'b0;
            pad_dout1 <= 1'b0;
          end else begin
            cnt       <= cnt - 1'b1;
            pad_dout0 <= tx_sh[WORD_W-1];
            pad_dout1 <= tx_sh[WORD_W-2];
            tx_sh     <= tx_sh << 2;
          end
        end
        RX: begin
          // Counter runs down, so the discarded leading samples are the high counts.
          if (cnt < CNT_W'(HALF)) rx_sh <= rx_next;
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= id_q ? 2'b10 : 2'b01;
            resp_rdata <= rx_next;
            pad_latch  <= 1'b1;
            pad_cken   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          resp_valid <= 2'b00;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (enter_tx) begin
        state     <= TX;
        cnt       <= CNT_W'(HALF - 1);
        pad_oe    <= 1'b1;
        pad_cken  <= 1'b1;
        pad_dout0 <= tx_src[WORD_W-1];
        pad_dout1 <= tx_src[WORD_W-2];
        tx_sh     <= tx_src << 2;
      end
      if (enter_rx) begin
        state     <= RX;
        cnt       <= CNT_W'(RX_N - 1);
        pad_oe    <= 1'b0;
        pad_cken  <= 1'b1;
        pad_latch <= 1'b0;
      end
    end
  end

endmodule
